// File: rtl/store_configs.sv
// store_configs: parses 22-byte configuration packets from a UART byte stream
// into a 32-entry A-line table (pulse shape + eight channel delays), keeps the
// channel mask / A-line index of the last committed packet, and presents one
// selected table entry to the downstream pulse generator.
module store_configs (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  uart_data,
   input  logic        new_data,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [4:0]  which_aline,
   output logic        intaking_configs,
   output logic [7:0]  channel_select,
   output logic [4:0]  aline_select,
   output logic [31:0] pulse_shape,
   output logic [15:0] ch0delay,
   output logic [15:0] ch1delay,
   output logic [15:0] ch2delay,
   output logic [15:0] ch3delay,
   output logic [15:0] ch4delay,
   output logic [15:0] ch5delay,
   output logic [15:0] ch6delay,
   output logic [15:0] ch7delay
);

   localparam int unsigned N_ALINES   = 32;
   localparam int unsigned N_CH       = 8;
   localparam int unsigned AL_W       = 5;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned SHAPE_W    = 32;
   localparam int unsigned DELAY_W    = 16;
   localparam int unsigned LAST_BYTE  = 21;
   // Bytes 2..20 are staged; byte 21 is taken straight from uart_data on commit.
   localparam int unsigned BODY_BYTES = 19;
   localparam int unsigned BODY_W     = BODY_BYTES * 8;

   // One table entry; delay[0] sits in the most significant slot so the
   // MSB-first byte stream lines up with the packed layout directly.
   typedef struct packed {
      logic [SHAPE_W-1:0]                shape;
      logic [0:N_CH-1][DELAY_W-1:0]      delay;
   } entry_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_nd_q;
   logic                r_intaking;
   logic [7:0]          r_cs_stg;
   logic [AL_W-1:0]     r_al_stg;
   logic [BODY_W-1:0]   r_body;
   logic [7:0]          r_channel_select;
   logic [AL_W-1:0]     r_aline_select;
   entry_t              r_mem [N_ALINES];
   entry_t              r_rd_entry;

   logic                w_strobe;
   logic                w_commit;
   entry_t              w_entry;

   // One strobe per 0->1 transition of the byte-available level.
   assign w_strobe = new_data & ~r_nd_q;

   // Last byte of an intact packet arriving while intake is still enabled.
   assign w_commit = (r_state == S_RECV) && wr_en && w_strobe &&
                     (r_cnt == CNT_W'(LAST_BYTE));

   // Staged body plus the in-flight final byte form the complete entry.
   assign w_entry = entry_t'({r_body, uart_data});

   // Edge-detect register for new_data; starts high so a level already
   // present out of reset does not count as a byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nd_q <= 1'b1;
      end else begin
         r_nd_q <= new_data;
      end
   end

   // Packet intake state machine with byte counter and staging registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_intaking <= 1'b0;
         r_cs_stg   <= '0;
         r_al_stg   <= '0;
         r_body     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_strobe && wr_en) begin
                  r_cs_stg   <= uart_data;
                  r_cnt      <= CNT_W'(1);
                  r_state    <= S_RECV;
                  r_intaking <= 1'b1;
               end
            end
            S_RECV: begin
               if (!wr_en) begin
                  // Abort: staged bytes are simply overwritten by the next packet.
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  r_intaking <= 1'b0;
               end else if (w_strobe) begin
                  if (r_cnt == CNT_W'(LAST_BYTE)) begin
                     r_state    <= S_IDLE;
                     r_cnt      <= '0;
                     r_intaking <= 1'b0;
                  end else begin
                     if (r_cnt == CNT_W'(1)) begin
                        r_al_stg <= uart_data[AL_W-1:0];
                     end else begin
                        r_body <= {r_body[BODY_W-9:0], uart_data};
                     end
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= '0;
               r_intaking <= 1'b0;
            end
         endcase
      end
   end

   // Atomic commit of table entry and global selects on the final byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_ALINES; i++) begin
            r_mem[i] <= '0;
         end
         r_channel_select <= '0;
         r_aline_select   <= '0;
      end else if (w_commit) begin
         r_mem[r_al_stg]  <= w_entry;
         r_channel_select <= r_cs_stg;
         r_aline_select   <= r_al_stg;
      end
   end

   // Read port; sees pre-commit contents when it coincides with a commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_entry <= '0;
      end else if (rd_en) begin
         r_rd_entry <= r_mem[which_aline];
      end
   end

   assign intaking_configs = r_intaking;
   assign channel_select   = r_channel_select;
   assign aline_select     = r_aline_select;
   assign pulse_shape      = r_rd_entry.shape;
   assign ch0delay         = r_rd_entry.delay[0];
   assign ch1delay         = r_rd_entry.delay[1];
   assign ch2delay         = r_rd_entry.delay[2];
   assign ch3delay         = r_rd_entry.delay[3];
   assign ch4delay         = r_rd_entry.delay[4];
   assign ch5delay         = r_rd_entry.delay[5];
   assign ch6delay         = r_rd_entry.delay[6];
   assign ch7delay         = r_rd_entry.delay[7];

endmodule

// File: tb/tb_store_configs.sv
// Directed testbench for store_configs: packet intake, table read, abort,
// held new_data, mid-packet reset and read/commit collision.
module tb_store_configs;

   logic        clk;
   logic        rst;
   logic [7:0]  uart_data;
   logic        new_data;
   logic        wr_en;
   logic        rd_en;
   logic [4:0]  which_aline;
   logic        intaking_configs;
   logic [7:0]  channel_select;
   logic [4:0]  aline_select;
   logic [31:0] pulse_shape;
   logic [15:0] ch0delay, ch1delay, ch2delay, ch3delay;
   logic [15:0] ch4delay, ch5delay, ch6delay, ch7delay;
   logic [15:0] dly [8];

   logic [7:0]  pkt [22];
   int          checks;
   int          errors;

   store_configs dut (
      .clk              (clk),
      .rst              (rst),
      .uart_data        (uart_data),
      .new_data         (new_data),
      .wr_en            (wr_en),
      .rd_en            (rd_en),
      .which_aline      (which_aline),
      .intaking_configs (intaking_configs),
      .channel_select   (channel_select),
      .aline_select     (aline_select),
      .pulse_shape      (pulse_shape),
      .ch0delay         (ch0delay),
      .ch1delay         (ch1delay),
      .ch2delay         (ch2delay),
      .ch3delay         (ch3delay),
      .ch4delay         (ch4delay),
      .ch5delay         (ch5delay),
      .ch6delay         (ch6delay),
      .ch7delay         (ch7delay)
   );

   assign dly[0] = ch0delay;
   assign dly[1] = ch1delay;
   assign dly[2] = ch2delay;
   assign dly[3] = ch3delay;
   assign dly[4] = ch4delay;
   assign dly[5] = ch5delay;
   assign dly[6] = ch6delay;
   assign dly[7] = ch7delay;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a packet image: channel mask, A-line byte, shape, delays base+n.
   task automatic fill_pkt(input logic [7:0] cs, input logic [7:0] al,
                           input logic [31:0] shape, input logic [15:0] base);
      logic [15:0] d;
      pkt[0] = cs;
      pkt[1] = al;
      pkt[2] = shape[31:24];
      pkt[3] = shape[23:16];
      pkt[4] = shape[15:8];
      pkt[5] = shape[7:0];
      for (int n = 0; n < 8; n++) begin
         d = base + 16'(n);
         pkt[6 + 2*n] = d[15:8];
         pkt[7 + 2*n] = d[7:0];
      end
   endtask

   // One UART byte: new_data high for 'hold' cycles, then low for 5 cycles.
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      uart_data = b;
      new_data  = 1'b1;
      repeat (hold) @(negedge clk);
      new_data  = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_read(input logic [4:0] al);
      @(negedge clk);
      which_aline = al;
      rd_en       = 1'b1;
      @(negedge clk);
      rd_en       = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (intaking_configs !== 1'b0) begin
         errors++;
         $display("FAIL reset_intaking: got %b expected 0", intaking_configs);
      end
      checks++;
      if (channel_select !== 8'h00) begin
         errors++;
         $display("FAIL reset_cs: got %h expected 00", channel_select);
      end
      checks++;
      if (aline_select !== 5'd0) begin
         errors++;
         $display("FAIL reset_as: got %0d expected 0", aline_select);
      end
      checks++;
      if (pulse_shape !== 32'h0) begin
         errors++;
         $display("FAIL reset_shape: got %h expected 0", pulse_shape);
      end
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (dly[n] !== 16'h0) begin
            errors++;
            $display("FAIL reset_ch%0d: got %h expected 0", n, dly[n]);
         end
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_packet;
      fill_pkt(8'hA5, 8'h03, 32'hDEADBEEF, 16'h0100);
      send_byte(pkt[0], 5);
      checks++;
      if (intaking_configs !== 1'b1) begin
         errors++;
         $display("FAIL full_intaking_b0: got %b expected 1", intaking_configs);
      end
      for (int i = 1; i < 21; i++) send_byte(pkt[i], 5);
      checks++;
      if (intaking_configs !== 1'b1) begin
         errors++;
         $display("FAIL full_intaking_b20: got %b expected 1", intaking_configs);
      end
      checks++;
      if (channel_select !== 8'h00) begin
         errors++;
         $display("FAIL full_cs_partial: got %h expected 00", channel_select);
      end
      send_byte(pkt[21], 5);
      checks++;
      if (intaking_configs !== 1'b0) begin
         errors++;
         $display("FAIL full_intaking_done: got %b expected 0", intaking_configs);
      end
      checks++;
      if (channel_select !== 8'hA5) begin
         errors++;
         $display("FAIL full_cs: got %h expected a5", channel_select);
      end
      checks++;
      if (aline_select !== 5'd3) begin
         errors++;
         $display("FAIL full_as: got %0d expected 3", aline_select);
      end
      do_read(5'd3);
      checks++;
      if (pulse_shape !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL full_shape: got %h expected deadbeef", pulse_shape);
      end
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (dly[n] !== 16'h0100 + 16'(n)) begin
            errors++;
            $display("FAIL full_ch%0d: got %h expected %h", n, dly[n], 16'h0100 + 16'(n));
         end
      end
   endtask

   task automatic test_unwritten;
      do_read(5'd4);
      checks++;
      if (pulse_shape !== 32'h0) begin
         errors++;
         $display("FAIL unwritten_shape: got %h expected 0", pulse_shape);
      end
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (dly[n] !== 16'h0) begin
            errors++;
            $display("FAIL unwritten_ch%0d: got %h expected 0", n, dly[n]);
         end
      end
   endtask

   task automatic test_abort;
      fill_pkt(8'h11, 8'h07, 32'hFFFFFFFF, 16'hFFF0);
      for (int i = 0; i < 10; i++) send_byte(pkt[i], 5);
      checks++;
      if (intaking_configs !== 1'b1) begin
         errors++;
         $display("FAIL abort_intaking_pre: got %b expected 1", intaking_configs);
      end
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      wr_en = 1'b1;
      checks++;
      if (intaking_configs !== 1'b0) begin
         errors++;
         $display("FAIL abort_intaking_post: got %b expected 0", intaking_configs);
      end
      do_read(5'd7);
      checks++;
      if (pulse_shape !== 32'h0) begin
         errors++;
         $display("FAIL abort_shape: got %h expected 0", pulse_shape);
      end
      checks++;
      if (ch0delay !== 16'h0) begin
         errors++;
         $display("FAIL abort_ch0: got %h expected 0", ch0delay);
      end
      checks++;
      if (channel_select !== 8'hA5) begin
         errors++;
         $display("FAIL abort_cs: got %h expected a5", channel_select);
      end
   endtask

   task automatic test_held_new_data;
      // A-line byte 0xE5 also exercises the ignored upper bits.
      fill_pkt(8'h3C, 8'hE5, 32'h01020304, 16'h0A00);
      send_byte(pkt[0], 20);
      checks++;
      if (dut.r_cnt !== 5'd1) begin
         errors++;
         $display("FAIL held_count: got %0d expected 1", dut.r_cnt);
      end
      for (int i = 1; i < 21; i++) send_byte(pkt[i], 5);
      checks++;
      if (intaking_configs !== 1'b1) begin
         errors++;
         $display("FAIL held_intaking_b20: got %b expected 1", intaking_configs);
      end
      send_byte(pkt[21], 5);
      checks++;
      if (channel_select !== 8'h3C) begin
         errors++;
         $display("FAIL held_cs: got %h expected 3c", channel_select);
      end
      checks++;
      if (aline_select !== 5'd5) begin
         errors++;
         $display("FAIL held_as: got %0d expected 5", aline_select);
      end
      do_read(5'd5);
      checks++;
      if (pulse_shape !== 32'h01020304) begin
         errors++;
         $display("FAIL held_shape: got %h expected 01020304", pulse_shape);
      end
      checks++;
      if (ch7delay !== 16'h0A07) begin
         errors++;
         $display("FAIL held_ch7: got %h expected 0a07", ch7delay);
      end
   endtask

   task automatic test_collision;
      fill_pkt(8'h77, 8'h03, 32'h12345678, 16'h0300);
      for (int i = 0; i < 21; i++) send_byte(pkt[i], 5);
      @(negedge clk);
      uart_data   = pkt[21];
      new_data    = 1'b1;
      rd_en       = 1'b1;
      which_aline = 5'd3;
      @(negedge clk);
      rd_en       = 1'b0;
      checks++;
      if (pulse_shape !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL collide_old_shape: got %h expected deadbeef", pulse_shape);
      end
      checks++;
      if (ch0delay !== 16'h0100) begin
         errors++;
         $display("FAIL collide_old_ch0: got %h expected 0100", ch0delay);
      end
      checks++;
      if (channel_select !== 8'h77) begin
         errors++;
         $display("FAIL collide_cs: got %h expected 77", channel_select);
      end
      checks++;
      if (intaking_configs !== 1'b0) begin
         errors++;
         $display("FAIL collide_intaking: got %b expected 0", intaking_configs);
      end
      repeat (3) @(negedge clk);
      new_data = 1'b0;
      repeat (3) @(negedge clk);
      do_read(5'd3);
      checks++;
      if (pulse_shape !== 32'h12345678) begin
         errors++;
         $display("FAIL collide_new_shape: got %h expected 12345678", pulse_shape);
      end
      checks++;
      if (ch7delay !== 16'h0307) begin
         errors++;
         $display("FAIL collide_new_ch7: got %h expected 0307", ch7delay);
      end
   endtask

   task automatic test_reset_mid_packet;
      fill_pkt(8'h99, 8'h0B, 32'hAAAAAAAA, 16'h5550);
      for (int i = 0; i < 13; i++) send_byte(pkt[i], 5);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (intaking_configs !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_intaking: got %b expected 0", intaking_configs);
      end
      checks++;
      if (channel_select !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_cs: got %h expected 00", channel_select);
      end
      checks++;
      if (aline_select !== 5'd0) begin
         errors++;
         $display("FAIL rstmid_as: got %0d expected 0", aline_select);
      end
      checks++;
      if (pulse_shape !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_shape: got %h expected 0", pulse_shape);
      end
      checks++;
      if (ch0delay !== 16'h0) begin
         errors++;
         $display("FAIL rstmid_ch0: got %h expected 0", ch0delay);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      do_read(5'd3);
      checks++;
      if (pulse_shape !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_cleared: got %h expected 0", pulse_shape);
      end
      fill_pkt(8'h5A, 8'h09, 32'hCAFEF00D, 16'h2000);
      for (int i = 0; i < 22; i++) send_byte(pkt[i], 5);
      checks++;
      if (channel_select !== 8'h5A) begin
         errors++;
         $display("FAIL rstmid_new_cs: got %h expected 5a", channel_select);
      end
      checks++;
      if (aline_select !== 5'd9) begin
         errors++;
         $display("FAIL rstmid_new_as: got %0d expected 9", aline_select);
      end
      do_read(5'd9);
      checks++;
      if (pulse_shape !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rstmid_new_shape: got %h expected cafef00d", pulse_shape);
      end
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (dly[n] !== 16'h2000 + 16'(n)) begin
            errors++;
            $display("FAIL rstmid_new_ch%0d: got %h expected %h", n, dly[n], 16'h2000 + 16'(n));
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b0;
      uart_data   = 8'h00;
      new_data    = 1'b0;
      wr_en       = 1'b1;
      rd_en       = 1'b0;
      which_aline = 5'd0;
      test_reset;
      test_full_packet;
      test_unwritten;
      test_abort;
      test_held_new_data;
      test_collision;
      test_reset_mid_packet;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
